// File: rtl/spi_xfer_ctrl.sv
// Sequencer for the SD-card SPI shift datapath: mode-0 SCLK/CS generation,
// datapath load/shift strobes, TX FIFO pops and byte/transfer completion pulses.
module spi_xfer_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 10
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             xfer_req,
    input  logic [1:0]       src_sel,
    input  logic [LEN_W-1:0] xfer_len,
    input  logic             hold_cs,
    input  logic             abort,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    output logic [1:0]       line_select,
    output logic             load_enable,
    output logic             byte_received,
    output logic             shift_enable,
    output logic             sclk,
    output logic             cs_n,
    output logic             byte_done,
    output logic             xfer_done,
    output logic             busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [1:0] SRC_FIFO = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       src_q, src_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             hold_q, hold_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;
    logic [2:0]       bit_q, bit_d;
    logic             go_q, go_d;
    logic             cs_n_q, cs_n_d;

    logic             sclk_q, shift_q, load_q, fifo_rd_q;
    logic             byte_done_q, xfer_done_q, busy_q;
    logic [1:0]       line_sel_q;

    // go_q is decided one cycle ahead so the LOAD-cycle strobes come from flops;
    // only this block pops the FIFO, so a one-cycle-old empty flag is safe.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        rem_d   = rem_q;
        hold_d  = hold_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        go_d    = go_q;
        cs_n_d  = cs_n_q;

        case (state_q)
            S_IDLE: begin
                if (xfer_req) begin
                    src_d = src_sel;
                    if (xfer_len != '0) begin
                        rem_d   = xfer_len;
                        hold_d  = hold_cs;
                        cs_n_d  = 1'b0;
                        go_d    = !((src_sel == SRC_FIFO) && fifo_empty);
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (go_q) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = 3'd0;
                    go_d    = 1'b0;
                end else begin
                    go_d = !((src_q == SRC_FIFO) && fifo_empty);
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (phase_q) begin
                        phase_d = 1'b0;
                        if (bit_q == 3'd7) state_d = S_GAP;
                        else               bit_d   = bit_q + 3'd1;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
                if (rem_q > LEN_W'(1)) begin
                    state_d = S_LOAD;
                    go_d    = !((src_q == SRC_FIFO) && fifo_empty);
                end else begin
                    state_d = S_DONE;
                    if (!hold_q) cs_n_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            rem_d   = '0;
            cs_n_d  = 1'b1;
            go_d    = 1'b0;
            div_d   = '0;
            phase_d = 1'b0;
            bit_d   = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            src_q       <= 2'b00;
            rem_q       <= '0;
            hold_q      <= 1'b0;
            div_q       <= '0;
            phase_q     <= 1'b0;
            bit_q       <= 3'd0;
            go_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            shift_q     <= 1'b0;
            load_q      <= 1'b0;
            fifo_rd_q   <= 1'b0;
            byte_done_q <= 1'b0;
            xfer_done_q <= 1'b0;
            busy_q      <= 1'b0;
            line_sel_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            rem_q       <= rem_d;
            hold_q      <= hold_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            go_q        <= go_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= (state_d == S_SHIFT) && phase_d;
            shift_q     <= (state_d == S_SHIFT) && phase_d && (div_d == DIV_LAST);
            load_q      <= (state_d == S_LOAD) && go_d;
            fifo_rd_q   <= (state_d == S_LOAD) && go_d && (src_d == SRC_FIFO);
            byte_done_q <= (state_d == S_GAP);
            xfer_done_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
            line_sel_q  <= (state_d == S_IDLE) ? 2'b00 : src_d;
        end
    end

    assign sclk          = sclk_q;
    assign cs_n          = cs_n_q;
    assign shift_enable  = shift_q;
    assign load_enable   = load_q;
    assign byte_received = load_q;
    assign fifo_rd       = fifo_rd_q;
    assign byte_done     = byte_done_q;
    assign xfer_done     = xfer_done_q;
    assign busy          = busy_q;
    assign line_select   = line_sel_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a datapath model, a mode-0 slave that
// always answers 0xA5, and byte scoreboards for MOSI and received data.
module tb_spi_xfer_ctrl;
    localparam int CLK_DIV = 4;
    localparam int LEN_W   = 10;
    localparam logic [7:0] SLAVE_TX = 8'hA5;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             xfer_req;
    logic [1:0]       src_sel;
    logic [LEN_W-1:0] xfer_len;
    logic             hold_cs;
    logic             abort;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [1:0]       line_select;
    logic             load_enable, byte_received, shift_enable;
    logic             sclk, cs_n, byte_done, xfer_done, busy;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk(clk), .n_rst(n_rst), .xfer_req(xfer_req), .src_sel(src_sel),
        .xfer_len(xfer_len), .hold_cs(hold_cs), .abort(abort), .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd), .line_select(line_select), .load_enable(load_enable),
        .byte_received(byte_received), .shift_enable(shift_enable), .sclk(sclk),
        .cs_n(cs_n), .byte_done(byte_done), .xfer_done(xfer_done), .busy(busy)
    );

    int compared = 0;
    int mism = 0;

    // TX FIFO (show-ahead) and datapath shift register
    logic [7:0] mem [0:7];
    logic [3:0] wr_p = 4'd0;
    logic [3:0] rd_p = 4'd0;
    logic [7:0] cmd_byte = 8'h00;
    logic [7:0] dp_sr = 8'h00;
    logic       mosi, miso;
    assign fifo_empty = (rd_p == wr_p);
    assign mosi = dp_sr[7];

    always @(posedge clk) begin
        if (load_enable && byte_received) begin
            case (line_select)
                2'b10:   dp_sr <= cmd_byte;
                2'b01:   dp_sr <= mem[rd_p[2:0]];
                default: dp_sr <= dp_sr;
            endcase
        end else if (shift_enable) begin
            dp_sr <= {dp_sr[6:0], miso};
        end
        if (fifo_rd) rd_p <= rd_p + 4'd1;
    end

    // Mode-0 slave: samples MOSI on SCLK rise, advances MISO on SCLK fall
    logic [7:0] s_rx = 8'h00;
    logic [2:0] s_cnt = 3'd0;
    logic [2:0] s_oidx = 3'd0;
    logic [7:0] slave_tx = SLAVE_TX;
    assign miso = slave_tx[3'd7 - s_oidx];

    logic [7:0] exp_mosi[$], obs_mosi[$], exp_rx[$], obs_rx[$];

    always @(posedge sclk or negedge sclk or posedge cs_n) begin
        if (cs_n) begin
            s_cnt  <= 3'd0;
            s_oidx <= 3'd0;
        end else if (sclk) begin
            s_rx  <= {s_rx[6:0], mosi};
            s_cnt <= s_cnt + 3'd1;
            if (s_cnt == 3'd7) obs_mosi.push_back({s_rx[6:0], mosi});
        end else begin
            s_oidx <= s_oidx + 3'd1;
        end
    end

    // Event counters: 0 sclk rise, 1 shift, 2 fifo_rd, 3 byte_done, 4 xfer_done,
    // 5 cs_n rise, 6 cs_n fall, 7 wrong line_select while busy, 8 bad sclk-high width
    int cnt [0:8] = '{default: 0};
    int base [0:8];
    logic [1:0] exp_ls = 2'b00;
    logic sclk_p = 1'b0;
    logic cs_p = 1'b1;
    int hi_run = 0;

    always @(negedge clk) begin
        sclk_p <= sclk;
        cs_p   <= cs_n;
        if (sclk && !sclk_p)            cnt[0] <= cnt[0] + 1;
        if (shift_enable)               cnt[1] <= cnt[1] + 1;
        if (fifo_rd)                    cnt[2] <= cnt[2] + 1;
        if (byte_done)                  cnt[3] <= cnt[3] + 1;
        if (xfer_done)                  cnt[4] <= cnt[4] + 1;
        if (cs_n && !cs_p)              cnt[5] <= cnt[5] + 1;
        if (!cs_n && cs_p)              cnt[6] <= cnt[6] + 1;
        if (busy && line_select != exp_ls) cnt[7] <= cnt[7] + 1;
        if (!n_rst) begin
            hi_run <= 0;
        end else if (sclk) begin
            hi_run <= hi_run + 1;
        end else if (sclk_p) begin
            if (hi_run != CLK_DIV) cnt[8] <= cnt[8] + 1;
            hi_run <= 0;
        end
        if (n_rst && byte_done) obs_rx.push_back(dp_sr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int d(input int i);
        return cnt[i] - base[i];
    endfunction

    function automatic logic [10:0] outv();
        return {sclk, cs_n, busy, line_select, load_enable, byte_received,
                shift_enable, fifo_rd, byte_done, xfer_done};
    endfunction

    task automatic snap();
        base = cnt;
    endtask

    task automatic fifo_push(input logic [7:0] b);
        mem[wr_p[2:0]] = b;
        wr_p = wr_p + 4'd1;
    endtask

    task automatic start(input logic [1:0] src, input int len, input logic hold);
        xfer_req = 1'b1;
        src_sel  = src;
        xfer_len = LEN_W'(len);
        hold_cs  = hold;
        @(negedge clk);
        xfer_req = 1'b0;
    endtask

    task automatic wait_for(input string tag, input bit xd, input int max);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < max) begin
            @(negedge clk);
            n++;
            seen = xd ? xfer_done : byte_done;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_mosi_count"}, obs_mosi.size(), exp_mosi.size());
        while (obs_mosi.size() > 0 && exp_mosi.size() > 0)
            chk({tag, "_mosi_byte"}, 32'(obs_mosi.pop_front()), 32'(exp_mosi.pop_front()));
        chk({tag, "_rx_count"}, obs_rx.size(), exp_rx.size());
        while (obs_rx.size() > 0 && exp_rx.size() > 0)
            chk({tag, "_rx_byte"}, 32'(obs_rx.pop_front()), 32'(exp_rx.pop_front()));
        obs_mosi.delete(); exp_mosi.delete(); obs_rx.delete(); exp_rx.delete();
    endtask

    initial begin
        int n, first, sh, bad;
        n_rst = 1'b0; xfer_req = 1'b0; src_sel = 2'b00; xfer_len = '0;
        hold_cs = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(outv()), 32'h200);
        n_rst = 1'b1;
        @(negedge clk);

        // 1: single command byte
        snap(); cmd_byte = 8'h3C; exp_ls = 2'b10;
        exp_mosi.push_back(8'h3C); exp_rx.push_back(SLAVE_TX);
        start(2'b10, 1, 1'b0);
        chk("t1_cs_low_after_req", 32'(cs_n), 32'd0);
        chk("t1_load_strobes", 32'({load_enable, byte_received, fifo_rd}), 32'b110);
        n = 0; first = -1;
        while (n < 200 && !byte_done) begin
            @(negedge clk);
            n++;
            if (sclk && first < 0) first = n;
        end
        // LOAD, then CLK_DIV low clocks, then SCLK rises; GAP ends a 16*CLK_DIV+2 clk byte
        chk("t1_first_rise", first, CLK_DIV + 1);
        chk("t1_byte_done_cycle", n, 16 * CLK_DIV + 1);
        @(negedge clk);
        chk("t1_xfer_done_cs_high", 32'({xfer_done, cs_n}), 32'b11);
        @(negedge clk);
        chk("t1_idle", 32'({busy, cs_n, sclk, line_select}), 32'b01000);
        chk("t1_sclk_rises", d(0), 8);
        chk("t1_shifts", d(1), 8);
        chk("t1_high_width_errs", d(8), 0);
        drain("t1");

        // 2: three FIFO bytes
        snap(); exp_ls = 2'b01;
        fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
        exp_mosi.push_back(8'h11); exp_mosi.push_back(8'h22); exp_mosi.push_back(8'h33);
        repeat (3) exp_rx.push_back(SLAVE_TX);
        start(2'b01, 3, 1'b0);
        wait_for("t2_xfer", 1'b1, 400);
        @(negedge clk);
        chk("t2_fifo_rd", d(2), 3);
        chk("t2_byte_done", d(3), 3);
        chk("t2_sclk_rises", d(0), 24);
        chk("t2_xfer_done", d(4), 1);
        chk("t2_line_select_bad", d(7), 0);
        chk("t2_fifo_drained", 32'(fifo_empty), 32'd1);
        drain("t2");

        // 3: FIFO stall before byte 2
        snap(); exp_ls = 2'b01;
        fifo_push(8'h5A);
        exp_mosi.push_back(8'h5A); exp_mosi.push_back(8'h6B);
        exp_rx.push_back(SLAVE_TX); exp_rx.push_back(SLAVE_TX);
        start(2'b01, 2, 1'b0);
        wait_for("t3_byte1", 1'b0, 200);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (sclk || shift_enable || load_enable || fifo_rd || cs_n || !busy) bad++;
        end
        chk("t3_stall_quiet_cycles", bad, 0);
        fifo_push(8'h6B);
        wait_for("t3_xfer", 1'b1, 200);
        @(negedge clk);
        chk("t3_fifo_rd", d(2), 2);
        chk("t3_byte_done", d(3), 2);
        chk("t3_shifts", d(1), 16);
        drain("t3");

        // 4: hold_cs, then recirculate the received byte
        snap(); cmd_byte = 8'hC3; exp_ls = 2'b10;
        exp_mosi.push_back(8'hC3); exp_rx.push_back(SLAVE_TX);
        start(2'b10, 1, 1'b1);
        wait_for("t4_xfer1", 1'b1, 200);
        chk("t4_cs_held_done", 32'(cs_n), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_cs_held_idle", 32'(cs_n), 32'd0);
        exp_ls = 2'b00;
        exp_mosi.push_back(SLAVE_TX); exp_rx.push_back(SLAVE_TX);
        start(2'b00, 1, 1'b0);
        wait_for("t4_xfer2", 1'b1, 200);
        chk("t4_cs_release", 32'(cs_n), 32'd1);
        @(negedge clk);
        chk("t4_cs_rises", d(5), 1);
        chk("t4_cs_falls", d(6), 1);
        chk("t4_byte_done", d(3), 2);
        chk("t4_line_select_bad", d(7), 0);
        drain("t4");

        // 5: abort during byte 1
        snap(); cmd_byte = 8'hF0; exp_ls = 2'b10;
        start(2'b10, 1, 1'b0);
        n = 0; sh = 0;
        while (sh < 3 && n < 200) begin
            if (shift_enable) sh++;
            if (sh < 3) begin
                @(negedge clk);
                n++;
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_abort_idle", 32'({busy, cs_n, sclk, shift_enable, byte_done, xfer_done}), 32'b010000);
        repeat (80) @(negedge clk);
        chk("t5_no_byte_done", d(3), 0);
        chk("t5_no_xfer_done", d(4), 0);
        cmd_byte = 8'h81;
        exp_mosi.push_back(8'h81); exp_rx.push_back(SLAVE_TX);
        start(2'b10, 1, 1'b0);
        wait_for("t5_xfer", 1'b1, 200);
        @(negedge clk);
        chk("t5_after_byte_done", d(3), 1);
        chk("t5_after_xfer_done", d(4), 1);
        drain("t5");

        // 6: zero-length request, then reset mid-SHIFT
        snap(); exp_ls = 2'b10;
        start(2'b10, 0, 1'b0);
        chk("t6_len0_done", 32'({xfer_done, busy, cs_n, sclk}), 32'b1110);
        repeat (2) @(negedge clk);
        chk("t6_len0_no_sclk", d(0), 0);
        chk("t6_len0_no_cs", d(6), 0);
        chk("t6_len0_xfer_done", d(4), 1);
        cmd_byte = 8'h99;
        start(2'b10, 1, 1'b0);
        repeat (12) @(negedge clk);
        chk("t6_in_shift", 32'({busy, cs_n}), 32'b10);
        #2 n_rst = 1'b0;
        #1 chk("t6_async_reset", 32'(outv()), 32'h200);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("t6_idle_after_reset", 32'(outv()), 32'h200);
        obs_mosi.delete(); obs_rx.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
